// File: rtl/fechadura_pkg.sv
// Shared definitions for the door-lock control unit: state codes, ASCII keys, timer sizing.
package fechadura_pkg;

  typedef enum logic [3:0] {
    S_INICIAL   = 4'b0000,
    S_ESPERA    = 4'b0001,
    S_ARMAZENA  = 4'b0010,
    S_COMPARA   = 4'b0011,
    S_ABERTO    = 4'b0100,
    S_ERRO      = 4'b0101,
    S_BLOQUEADO = 4'b0110
  } estado_t;

  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_9    = 8'h39;
  localparam logic [7:0] ASCII_AST  = 8'h2A;
  localparam logic [7:0] ASCII_HASH = 8'h23;
  localparam logic [7:0] ASCII_F    = 8'h46;

  localparam logic [3:0] DB_INVALIDO = 4'b1111;

  // Counter width able to hold the terminal count of the longest window.
  function automatic int unsigned largura_timer(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/contador_tempo.sv
// Saturating up-counter; fim flags the M-th cycle since the last clear.
module contador_tempo #(
  parameter int unsigned M = 8,
  parameter int unsigned W = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic fim
);

  localparam logic [W-1:0] TERMINAL = W'(M - 1);

  logic [W-1:0] contagem_q, contagem_d;

  // Clear dominates; count only while enabled and below terminal.
  always_comb begin
    contagem_d = contagem_q;
    if (clear) begin
      contagem_d = '0;
    end else if (enable && (contagem_q != TERMINAL)) begin
      contagem_d = contagem_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) contagem_q <= '0;
    else       contagem_q <= contagem_d;
  end

  assign fim = (contagem_q == TERMINAL);

endmodule

// File: rtl/fechadura_uc.sv
// Door-lock control unit: assembles keypad digits, checks the code, times open/lockout windows.
module fechadura_uc
  import fechadura_pkg::*;
#(
  parameter int unsigned N_DIGITOS      = 4,
  parameter logic [15:0] SENHA          = 16'h1234,
  parameter int unsigned TEMPO_ABERTO   = 50_000_000,
  parameter int unsigned MAX_TENTATIVAS = 3,
  parameter int unsigned TEMPO_BLOQUEIO = 500_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       fimRecepcao,
  input  logic [7:0] dado,
  output logic       abrir,
  output logic       bloqueado,
  output logic       erro,
  output logic [2:0] digitos,
  output logic [2:0] tentativas,
  output logic [3:0] dbEstado
);

  localparam int unsigned TW      = largura_timer(TEMPO_ABERTO, TEMPO_BLOQUEIO);
  localparam logic [2:0]  N_DIG   = 3'(N_DIGITOS);
  localparam logic [2:0]  MAX_T   = 3'(MAX_TENTATIVAS);
  localparam logic [15:0] MASCARA = 16'((64'd1 << (4 * N_DIGITOS)) - 64'd1);

  estado_t     estado_q, estado_d;
  logic [15:0] buffer_q, buffer_d;
  logic [2:0]  digitos_q, digitos_d;
  logic [2:0]  tentativas_q, tentativas_d;
  logic [3:0]  digito_q, digito_d;

  logic eh_digito, eh_ast, eh_hash, eh_f, igual, cabe_digito;
  logic no_aberto, no_bloqueio, fim_aberto, fim_bloqueio;

  assign eh_digito   = (dado >= ASCII_0) && (dado <= ASCII_9);
  assign eh_ast      = (dado == ASCII_AST);
  assign eh_hash     = (dado == ASCII_HASH);
  assign eh_f        = (dado == ASCII_F);
  assign cabe_digito = (digitos_q < N_DIG);
  assign igual       = (digitos_q == N_DIG) && ((buffer_q & MASCARA) == (SENHA & MASCARA));
  assign no_aberto   = (estado_q == S_ABERTO);
  assign no_bloqueio = (estado_q == S_BLOQUEADO);

  // Window timers are held clear outside their state, so each entry starts from zero.
  contador_tempo #(.M(TEMPO_ABERTO), .W(TW)) u_tempo_aberto (
    .clock  (clock),
    .reset  (reset),
    .clear  (!no_aberto),
    .enable (no_aberto),
    .fim    (fim_aberto)
  );

  contador_tempo #(.M(TEMPO_BLOQUEIO), .W(TW)) u_tempo_bloqueio (
    .clock  (clock),
    .reset  (reset),
    .clear  (!no_bloqueio),
    .enable (no_bloqueio),
    .fim    (fim_bloqueio)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado_q <= S_INICIAL;
    else       estado_q <= estado_d;
  end

  // Next-state logic.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      S_INICIAL: estado_d = S_ESPERA;
      S_ESPERA: begin
        if (fimRecepcao) begin
          if (eh_digito && cabe_digito) estado_d = S_ARMAZENA;
          else if (eh_hash)             estado_d = S_COMPARA;
        end
      end
      S_ARMAZENA: estado_d = S_ESPERA;
      S_COMPARA:  estado_d = igual ? S_ABERTO : S_ERRO;
      S_ABERTO: begin
        if (fim_aberto || (fimRecepcao && eh_f)) estado_d = S_ESPERA;
      end
      S_ERRO:      estado_d = ((tentativas_q + 3'd1) == MAX_T) ? S_BLOQUEADO : S_ESPERA;
      S_BLOQUEADO: if (fim_bloqueio) estado_d = S_ESPERA;
      default:     estado_d = S_INICIAL;
    endcase
  end

  // Moore output decode.
  always_comb begin
    abrir     = 1'b0;
    bloqueado = 1'b0;
    erro      = 1'b0;
    dbEstado  = DB_INVALIDO;
    case (estado_q)
      S_INICIAL, S_ESPERA, S_ARMAZENA, S_COMPARA: dbEstado = estado_q;
      S_ABERTO: begin
        abrir    = 1'b1;
        dbEstado = estado_q;
      end
      S_ERRO: begin
        erro     = 1'b1;
        dbEstado = estado_q;
      end
      S_BLOQUEADO: begin
        bloqueado = 1'b1;
        dbEstado  = estado_q;
      end
      default: dbEstado = DB_INVALIDO;
    endcase
  end

  // Digit buffer, digit count and failure count updates.
  always_comb begin
    buffer_d     = buffer_q;
    digitos_d    = digitos_q;
    tentativas_d = tentativas_q;
    digito_d     = digito_q;
    case (estado_q)
      S_INICIAL: begin
        buffer_d  = '0;
        digitos_d = '0;
      end
      S_ESPERA: begin
        if (fimRecepcao && eh_digito && cabe_digito) digito_d = dado[3:0];
        if (fimRecepcao && eh_ast) begin
          buffer_d  = '0;
          digitos_d = '0;
        end
      end
      S_ARMAZENA: begin
        buffer_d  = {buffer_q[11:0], digito_q};
        digitos_d = digitos_q + 3'd1;
      end
      S_COMPARA: begin
        buffer_d  = '0;
        digitos_d = '0;
        if (igual) tentativas_d = '0;
      end
      S_ERRO:      tentativas_d = tentativas_q + 3'd1;
      S_BLOQUEADO: if (fim_bloqueio) tentativas_d = '0;
      default: begin
        buffer_d  = '0;
        digitos_d = '0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buffer_q     <= '0;
      digitos_q    <= '0;
      tentativas_q <= '0;
      digito_q     <= '0;
    end else begin
      buffer_q     <= buffer_d;
      digitos_q    <= digitos_d;
      tentativas_q <= tentativas_d;
      digito_q     <= digito_d;
    end
  end

  assign digitos    = digitos_q;
  assign tentativas = tentativas_q;

endmodule

// File: tb/tb_fechadura_uc.sv
// Randomized bench for fechadura_uc against a timeline model of the lock behaviour.
module tb_fechadura_uc;

  localparam int T_ABERTO   = 8;
  localparam int T_BLOQUEIO = 16;
  localparam int MAX_T      = 3;
  localparam int N_DIG      = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       fimRecepcao = 1'b0;
  logic [7:0] dado = 8'h00;
  logic       abrir, bloqueado, erro;
  logic [2:0] digitos, tentativas;
  logic [3:0] dbEstado;

  fechadura_uc #(
    .N_DIGITOS      (N_DIG),
    .SENHA          (16'h1234),
    .TEMPO_ABERTO   (T_ABERTO),
    .MAX_TENTATIVAS (MAX_T),
    .TEMPO_BLOQUEIO (T_BLOQUEIO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .fimRecepcao (fimRecepcao),
    .dado        (dado),
    .abrir       (abrir),
    .bloqueado   (bloqueado),
    .erro        (erro),
    .digitos     (digitos),
    .tentativas  (tentativas),
    .dbEstado    (dbEstado)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: everything is expressed as edge indices of windows and events.
  int e = 0;
  bit chk_en = 1'b0;
  int q[$];
  int open_lo = 0, open_hi = -1, lock_lo = 0, lock_hi = -1;
  int erro_at = -10, compara_at = -10, arm_at = -10, rst_e = -10;
  int pre_size = 0;
  int tent_old = 0, tent_new = 0, tent_chg_at = 0;

  function automatic bit in_open(input int x);
    return (x >= open_lo) && (x <= open_hi);
  endfunction

  function automatic bit in_lock(input int x);
    return (x >= lock_lo) && (x <= lock_hi);
  endfunction

  function automatic int exp_estado(input int x);
    if (in_open(x))       return 4;
    if (in_lock(x))       return 6;
    if (x == erro_at)     return 5;
    if (x == compara_at)  return 3;
    if (x == arm_at)      return 2;
    if (x == rst_e)       return 0;
    return 1;
  endfunction

  task automatic model_reset();
    q.delete();
    open_lo = 0; open_hi = -1; lock_lo = 0; lock_hi = -1;
    erro_at = -10; compara_at = -10; arm_at = -10;
    pre_size = 0; tent_old = 0; tent_new = 0; tent_chg_at = 0;
  endtask

  // A byte sampled at edge p is judged by the state the lock held after edge p-1.
  task automatic model_byte(input int p, input logic [7:0] b);
    bit ok;
    if ((p - 1) == rst_e || (p - 1) == arm_at || (p - 1) == compara_at || (p - 1) == erro_at) return;
    if (in_lock(p - 1)) return;
    if (in_open(p - 1)) begin
      if (b == 8'h46) open_hi = p - 1;
      return;
    end
    if (b >= 8'h30 && b <= 8'h39) begin
      if (q.size() < N_DIG) begin
        q.push_back(int'(b) - 48);
        arm_at = p;
      end
    end else if (b == 8'h2A) begin
      q.delete();
    end else if (b == 8'h23) begin
      ok = (q.size() == N_DIG) && (q[0] == 1) && (q[1] == 2) && (q[2] == 3) && (q[3] == 4);
      pre_size = q.size();
      compara_at = p;
      q.delete();
      tent_old = tent_new;
      if (ok) begin
        open_lo = p + 1;
        open_hi = p + T_ABERTO;
        tent_new = 0;
        tent_chg_at = p + 1;
      end else begin
        erro_at = p + 1;
        tent_new = tent_old + 1;
        tent_chg_at = p + 2;
        if (tent_new == MAX_T) begin
          lock_lo = p + 2;
          lock_hi = p + 1 + T_BLOQUEIO;
        end
      end
    end
  endtask

  // Model advances on each rising edge from the stimulus it observes.
  always @(posedge clock) begin
    e = e + 1;
    if (reset) begin
      model_reset();
      rst_e = e;
      chk_en = 1'b0;
    end else begin
      chk_en = 1'b1;
      if (lock_lo <= lock_hi && e == lock_hi + 1) begin
        tent_old = tent_new;
        tent_new = 0;
        tent_chg_at = e;
      end
      if (fimRecepcao) model_byte(e, dado);
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clock) begin
    if (chk_en && !reset) begin
      check("abrir", int'(abrir), int'(in_open(e)));
      check("bloqueado", int'(bloqueado), int'(in_lock(e)));
      check("erro", int'(erro), int'(e == erro_at));
      check("dbEstado", int'(dbEstado), exp_estado(e));
      check("digitos", int'(digitos),
            (e == arm_at) ? q.size() - 1 : ((e == compara_at) ? pre_size : q.size()));
      check("tentativas", int'(tentativas), (e >= tent_chg_at) ? tent_new : tent_old);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clock);
    fimRecepcao = 1'b1;
    dado = b;
    @(negedge clock);
    fimRecepcao = 1'b0;
    dado = 8'($urandom);
    repeat (gap) @(negedge clock);
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_abrir"}, int'(abrir), 0);
    check({pfx, "_bloqueado"}, int'(bloqueado), 0);
    check({pfx, "_erro"}, int'(erro), 0);
    check({pfx, "_dbEstado"}, int'(dbEstado), 0);
    check({pfx, "_digitos"}, int'(digitos), 0);
    check({pfx, "_tentativas"}, int'(tentativas), 0);
  endtask

  // Reset asserted between edges must clear the outputs without a clock edge.
  task automatic async_reset(input string pfx);
    @(posedge clock);
    #2 reset = 1'b1;
    #1 check_zero(pfx);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got 1 expected 0");
    $fatal(1, "timeout");
  end

  initial begin
    int act;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_zero("reset");
    reset = 1'b0;

    send_str("1234#", 3);
    idle(12);
    send_str("1235#", 3);
    idle(4);
    send_str("1235#", 3);
    idle(4);
    send_str("1235#", 3);
    send_str("1234#", 1);
    idle(20);
    send_str("1234#", 3);
    idle(12);
    send_str("9*1234#", 3);
    idle(12);
    send_str("12345#", 3);
    idle(12);
    send_str("1234#", 1);
    send_byte(8'h46, 12);

    send_str("1234#", 4);
    check("pre_rst_abrir", int'(abrir), 1);
    async_reset("rst_aberto");
    idle(3);

    send_str("12#", 3);
    send_str("1#", 3);
    send_str("#", 3);
    check("pre_rst_bloqueado", int'(bloqueado), 1);
    check("pre_rst_tentativas", int'(tentativas), MAX_T);
    async_reset("rst_bloqueado");
    idle(3);
    send_str("1234#", 3);
    idle(12);

    for (int k = 0; k < 400; k++) begin
      act = int'($urandom_range(0, 9));
      case (act)
        0, 1:    send_str("1234#", int'($urandom_range(0, 4)));
        2, 3, 4: send_byte(8'(8'h30 + $urandom_range(0, 9)), int'($urandom_range(0, 6)));
        5:       send_byte(8'h23, int'($urandom_range(0, 6)));
        6:       send_byte(8'h2A, int'($urandom_range(0, 6)));
        7:       send_byte(8'h46, int'($urandom_range(0, 6)));
        8:       send_byte(8'($urandom), int'($urandom_range(0, 6)));
        default: idle(int'($urandom_range(1, 10)));
      endcase
    end
    idle(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
